// File: rtl/collect_2x1_rr_seq.sv
// Two-branch collector: each branch buffers words in its own FIFO, and the
// output merges the two streams with round-robin arbitration and a held selection.
module collect_2x1_rr_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              i_valid,
    input  logic [2*DATA_WIDTH-1:0] i_data_bus,
    input  logic                    i_en,
    input  logic                    i_ready,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data_bus,
    output logic                    o_src,
    output logic [1:0]              o_full,
    output logic [1:0]              o_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]                 nonempty;
    logic [1:0]                 pop_br;
    logic [1:0][DATA_WIDTH-1:0] head;
    logic                       sel;
    logic                       pop;
    logic                       rr_q, rr_d;
    logic                       lock_q, lock_d;
    logic                       lock_src_q, lock_src_d;

    for (genvar g = 0; g < 2; g++) begin : g_br
        logic [CW-1:0]         cnt_q, cnt_d;
        logic [AW-1:0]         wr_q, wr_d;
        logic [AW-1:0]         rd_q, rd_d;
        logic                  ovf_q, ovf_d;
        logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic                  full;
        logic                  push_req;
        logic                  push;

        assign full     = (cnt_q == CW'(FIFO_DEPTH));
        assign push_req = i_en & i_valid[g];
        // A full FIFO still accepts a push when it is being popped this cycle.
        assign push     = push_req & (~full | pop_br[g]);

        always_comb begin
            cnt_d = cnt_q;
            wr_d  = wr_q;
            rd_d  = rd_q;
            ovf_d = ovf_q | (push_req & full & ~pop_br[g]);
            if (push) wr_d = wr_q + AW'(1);
            if (pop_br[g]) rd_d = rd_q + AW'(1);
            case ({push, pop_br[g]})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
                wr_q  <= '0;
                rd_q  <= '0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                wr_q  <= wr_d;
                rd_q  <= rd_d;
                ovf_q <= ovf_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push) mem_q[wr_q] <= i_data_bus[g*DATA_WIDTH +: DATA_WIDTH];
        end

        assign nonempty[g]   = (cnt_q != '0);
        assign head[g]       = mem_q[rd_q];
        assign pop_br[g]     = pop & (sel == 1'(g));
        assign o_full[g]     = full;
        assign o_overflow[g] = ovf_q;
    end

    // A stalled word keeps its source until it is taken, regardless of rr.
    always_comb begin
        sel = 1'b0;
        if (lock_q)
            sel = lock_src_q;
        else if (nonempty == 2'b11)
            sel = rr_q;
        else
            sel = nonempty[1];
    end

    assign o_valid    = |nonempty;
    assign pop        = o_valid & i_ready;
    assign o_data_bus = o_valid ? head[sel] : '0;
    assign o_src      = o_valid & sel;

    always_comb begin
        rr_d       = pop ? ~sel : rr_q;
        lock_d     = o_valid & ~i_ready;
        lock_src_d = sel;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q       <= 1'b0;
            lock_q     <= 1'b0;
            lock_src_q <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end

endmodule

// File: tb/tb_collect_2x1_rr_seq.sv
// Bench for collect_2x1_rr_seq: directed scenarios followed by random traffic,
// all compared against a queue-based model of the merge behaviour.
module tb_collect_2x1_rr_seq;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    i_valid;
    logic [2*DW-1:0] i_data_bus;
    logic          i_en;
    logic          i_ready;
    logic          o_valid;
    logic [DW-1:0] o_data_bus;
    logic          o_src;
    logic [1:0]    o_full;
    logic [1:0]    o_overflow;

    int checks   = 0;
    int failures = 0;

    // Model state: one queue per branch, arbitration pointer, held source.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic          m_rr;
    logic          m_held;
    logic          m_held_src;
    logic [1:0]    m_ovf;

    collect_2x1_rr_seq #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data_bus (i_data_bus),
        .i_en       (i_en),
        .i_ready    (i_ready),
        .o_valid    (o_valid),
        .o_data_bus (o_data_bus),
        .o_src      (o_src),
        .o_full     (o_full),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_out(output logic v, output logic [DW-1:0] d, output logic s);
        v = (q0.size() != 0) || (q1.size() != 0);
        s = 1'b0;
        d = '0;
        if (v) begin
            if (m_held)                              s = m_held_src;
            else if (q0.size() != 0 && q1.size() != 0) s = m_rr;
            else                                     s = (q1.size() != 0);
            d = s ? q1[0] : q0[0];
        end
    endtask

    task automatic check_outputs(input string tag);
        logic v, s;
        logic [DW-1:0] d;
        model_out(v, d, s);
        chk({tag, ".valid"}, 64'(o_valid), 64'(v));
        chk({tag, ".data"},  64'(o_data_bus), 64'(d));
        chk({tag, ".src"},   64'(o_src), 64'(s));
        chk({tag, ".full"},  64'(o_full), 64'({q1.size() == DEPTH, q0.size() == DEPTH}));
        chk({tag, ".ovf"},   64'(o_overflow), 64'(m_ovf));
    endtask

    // Drive one cycle of inputs, check current outputs, then advance the model.
    task automatic step(input string tag, input logic [1:0] v, input logic [2*DW-1:0] d,
                        input logic en, input logic rdy);
        logic ov, s, pop;
        logic [DW-1:0] od;
        i_valid = v; i_data_bus = d; i_en = en; i_ready = rdy;
        check_outputs(tag);
        model_out(ov, od, s);
        @(posedge clk);
        pop = ov && rdy;
        if (pop) begin
            if (s) void'(q1.pop_front()); else void'(q0.pop_front());
            m_rr = ~s;
        end
        if (en && v[0]) begin
            if (q0.size() < DEPTH) q0.push_back(d[DW-1:0]); else m_ovf[0] = 1'b1;
        end
        if (en && v[1]) begin
            if (q1.size() < DEPTH) q1.push_back(d[2*DW-1:DW]); else m_ovf[1] = 1'b1;
        end
        m_held     = ov && !rdy;
        m_held_src = s;
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        q0.delete(); q1.delete();
        m_rr = 1'b0; m_held = 1'b0; m_held_src = 1'b0; m_ovf = 2'b00;
        check_outputs(tag);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; i_valid = '0; i_data_bus = '0; i_en = 1'b0; i_ready = 1'b0;
        q0.delete(); q1.delete();
        m_rr = 1'b0; m_held = 1'b0; m_held_src = 1'b0; m_ovf = 2'b00;
        @(negedge clk);
        do_reset("reset");

        // Single low-branch word
        step("single.push", 2'b01, {32'h0, 32'hAAAAAAAA}, 1'b1, 1'b1);
        chk("single.out_valid", 64'(o_valid), 64'd1);
        chk("single.out_data",  64'(o_data_bus), 64'hAAAAAAAA);
        step("single.pop",  2'b00, '0, 1'b1, 1'b1);
        step("single.empty", 2'b00, '0, 1'b1, 1'b1);

        // Simultaneous push on both branches from rr=0
        do_reset("rr.reset");
        step("rr.push", 2'b11, {32'hAAAAAAAA, 32'hBBBBBBBB}, 1'b1, 1'b1);
        chk("rr.first_src",  64'(o_src), 64'd0);
        chk("rr.first_data", 64'(o_data_bus), 64'hBBBBBBBB);
        step("rr.out1", 2'b00, '0, 1'b1, 1'b1);
        chk("rr.second_src",  64'(o_src), 64'd1);
        chk("rr.second_data", 64'(o_data_bus), 64'hAAAAAAAA);
        step("rr.out2", 2'b00, '0, 1'b1, 1'b1);

        // Backpressure with a later high-branch word
        do_reset("bp.reset");
        step("bp.low", 2'b01, {32'h0, 32'h11111111}, 1'b1, 1'b0);
        step("bp.high", 2'b10, {32'h22222222, 32'h0}, 1'b1, 1'b0);
        step("bp.hold1", 2'b00, '0, 1'b1, 1'b0);
        chk("bp.held_data", 64'(o_data_bus), 64'h11111111);
        step("bp.release", 2'b00, '0, 1'b1, 1'b1);
        chk("bp.next_data", 64'(o_data_bus), 64'h22222222);
        step("bp.drain", 2'b00, '0, 1'b1, 1'b1);

        // Overflow of the high branch, then drain
        do_reset("ovf.reset");
        for (int i = 1; i <= 5; i++)
            step("ovf.push", 2'b10, {32'(i), 32'h0}, 1'b1, 1'b0);
        chk("ovf.full_flag", 64'(o_full), 64'b10);
        chk("ovf.sticky",    64'(o_overflow), 64'b10);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf.drain_word", 64'(o_data_bus), 64'(i));
            step("ovf.drain", 2'b00, '0, 1'b1, 1'b1);
        end
        step("ovf.after", 2'b00, '0, 1'b1, 1'b1);

        // Push into a full FIFO while it is popped
        do_reset("fp.reset");
        for (int i = 1; i <= 4; i++)
            step("fp.fill", 2'b10, {32'(i), 32'h0}, 1'b1, 1'b0);
        step("fp.push9", 2'b10, {32'd9, 32'h0}, 1'b1, 1'b1);
        chk("fp.no_ovf", 64'(o_overflow), 64'b00);
        for (int i = 0; i < 5; i++)
            step("fp.drain", 2'b00, '0, 1'b1, 1'b1);

        // Reset mid-stream, then disabled writes
        for (int i = 1; i <= 3; i++)
            step("mr.fill", 2'b01, {32'h0, 32'(i + 100)}, 1'b1, 1'b0);
        do_reset("mr.reset");
        for (int i = 0; i < 4; i++)
            step("mr.en0", 2'b11, {32'hDEAD0000, 32'h0000BEEF}, 1'b0, 1'b1);
        chk("mr.still_empty", 64'(o_valid), 64'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset("rand.reset");
            step("rand",
                 2'($urandom_range(0, 3)),
                 {$urandom(), $urandom()},
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 9) < 5));
        end
        for (int i = 0; i < 10; i++)
            step("rand.drain", 2'b00, '0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
